hp_mul: RTL and testbench

- Pipelined IEEE 754 binary16 (half-precision) multiplier used in the DNN datapath MAC lanes.
- Takes two half-precision operands and produces their product with full special-value handling, subnormal support and round-to-nearest-even rounding.
- Two-stage registered pipeline with a valid flag travelling alongside the data.

---
 rtl/hp_mul_if.sv | 18 +
 rtl/hp_mul.sv | 168 ++++++++++++++++
 tb/tb_hp_mul.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hp_mul_if.sv
// Operand/result bundle for the binary16 multiplier lane.
interface hp_mul_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] p;

  modport master (
    output in_valid, a, b,
    input  out_valid, p
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, p
  );
endinterface

// File: rtl/hp_mul.sv
// Two-stage pipelined IEEE 754 binary16 multiplier.
// Stage 1 unpacks the operands, multiplies the significands and classifies specials.
// Stage 2 normalises, handles the subnormal range, rounds RNE and packs the result.
module hp_mul (
  input  logic     clk,
  input  logic     rst_n,
  hp_mul_if.slave  bus
);

  typedef enum logic [1:0] {
    KIND_FINITE,
    KIND_ZERO,
    KIND_INF,
    KIND_NAN
  } kind_t;

  // ---------------- stage 1 ----------------
  logic [4:0]        exp_a, exp_b;
  logic [9:0]        frac_a, frac_b;
  logic [10:0]       sig_a, sig_b;
  logic [4:0]        eff_a, eff_b;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  kind_t             kind_c;
  logic signed [7:0] exp_sum_c;
  logic [21:0]       prod_c;

  logic              s1_valid;
  logic              s1_sign;
  kind_t             s1_kind;
  logic signed [7:0] s1_exp;
  logic [21:0]       s1_prod;

  // Unpack operands, classify specials and form significand product / exponent sum
  always_comb begin
    exp_a  = bus.a[14:10];
    exp_b  = bus.b[14:10];
    frac_a = bus.a[9:0];
    frac_b = bus.b[9:0];
    sig_a  = {|exp_a, frac_a};
    sig_b  = {|exp_b, frac_b};
    eff_a  = (exp_a == 5'd0) ? 5'd1 : exp_a;
    eff_b  = (exp_b == 5'd0) ? 5'd1 : exp_b;
    nan_a  = (&exp_a) & (|frac_a);
    nan_b  = (&exp_b) & (|frac_b);
    inf_a  = (&exp_a) & ~(|frac_a);
    inf_b  = (&exp_b) & ~(|frac_b);
    zero_a = ~(|exp_a) & ~(|frac_a);
    zero_b = ~(|exp_b) & ~(|frac_b);

    if (nan_a || nan_b)
      kind_c = KIND_NAN;
    else if ((inf_a && zero_b) || (inf_b && zero_a))
      kind_c = KIND_NAN;
    else if (inf_a || inf_b)
      kind_c = KIND_INF;
    else if (zero_a || zero_b)
      kind_c = KIND_ZERO;
    else
      kind_c = KIND_FINITE;

    // Biased exponent of the product when its leading one sits at bit 20
    exp_sum_c = $signed({3'b000, eff_a}) + $signed({3'b000, eff_b}) - 8'sd15;
    prod_c    = 22'(sig_a) * 22'(sig_b);
  end

  // Stage 1 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_kind  <= KIND_ZERO;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_sign  <= bus.a[15] ^ bus.b[15];
      s1_kind  <= kind_c;
      s1_exp   <= exp_sum_c;
      s1_prod  <= prod_c;
    end
  end

  // ---------------- stage 2 ----------------
  logic [4:0]        lz;
  logic [21:0]       norm;
  logic signed [7:0] e_norm;
  logic [7:0]        sh_raw, sh;
  logic [43:0]       wide;
  logic [21:0]       mant;
  logic              sticky_x;
  logic              subn;
  logic [10:0]       keep;
  logic              guard, sticky, round_up;
  logic [11:0]       rsum;
  logic signed [7:0] e_fin;
  logic [9:0]        frac_fin;
  logic [15:0]       p_c;

  // Normalise, denormalise into the subnormal range, round RNE and pack
  always_comb begin
    // Leading-zero count from bit 21; the highest set bit is the last one to assign
    lz = 5'd22;
    for (int unsigned i = 0; i < 22; i++) begin
      if (s1_prod[i]) lz = 5'(21 - i);
    end
    norm   = s1_prod << lz;
    // Leading one now at bit 21, so the exponent gains one and loses lz
    e_norm = s1_exp + 8'sd1 - $signed({3'b000, lz});

    sh_raw   = '0;
    sh       = '0;
    wide     = '0;
    mant     = norm;
    sticky_x = 1'b0;
    subn     = 1'b0;
    if (e_norm < 8'sd1) begin
      // Result below the normal range: shift right, folding lost bits into sticky
      subn     = 1'b1;
      sh_raw   = 8'(8'sd1 - e_norm);
      sh       = (sh_raw > 8'd23) ? 8'd23 : sh_raw;
      wide     = {norm, 22'b0} >> sh;
      mant     = wide[43:22];
      sticky_x = |wide[21:0];
    end

    keep     = mant[21:11];
    guard    = mant[10];
    sticky   = (|mant[9:0]) | sticky_x;
    round_up = guard & (sticky | keep[0]);
    rsum     = {1'b0, keep} + 12'(round_up);

    if (subn) begin
      // A carry into bit 10 means the value rounded up to the smallest normal
      e_fin    = rsum[10] ? 8'sd1 : 8'sd0;
      frac_fin = rsum[9:0];
    end else if (rsum[11]) begin
      e_fin    = e_norm + 8'sd1;
      frac_fin = rsum[10:1];
    end else begin
      e_fin    = e_norm;
      frac_fin = rsum[9:0];
    end

    case (s1_kind)
      KIND_NAN:  p_c = 16'h7E00;
      KIND_INF:  p_c = {s1_sign, 15'h7C00};
      KIND_ZERO: p_c = {s1_sign, 15'h0000};
      default: begin
        if (e_fin >= 8'sd31)
          p_c = {s1_sign, 15'h7C00};
        else
          p_c = {s1_sign, e_fin[4:0], frac_fin};
      end
    endcase
  end

  // Stage 2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.p         <= '0;
    end else begin
      bus.out_valid <= s1_valid;
      bus.p         <= p_c;
    end
  end

endmodule

// File: tb/tb_hp_mul.sv
// Directed bench for hp_mul: a scoreboard queue holds expected products,
// filled when operands are driven and drained when out_valid is seen.
module tb_hp_mul;

  logic clk;
  logic rst_n;

  hp_mul_if bus ();

  hp_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [1:0]  vpipe;
  int          checks;
  int          failures;

  // Compare outputs against the scoreboard; called #1 after a rising edge
  task automatic check_outputs();
    logic [15:0] exp_p;
    checks++;
    assert (bus.out_valid === vpipe[1]) else begin
      failures++;
      $error("FAIL out_valid got=%b exp=%b", bus.out_valid, vpipe[1]);
    end
    if (bus.out_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow got=%0d exp=>0", sb.size());
      end
      if (sb.size() > 0) begin
        exp_p = sb.pop_front();
        checks++;
        assert (bus.p === exp_p) else begin
          failures++;
          $error("FAIL product got=%h exp=%h", bus.p, exp_p);
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and check what emerges
  task automatic step(input logic v, input logic [15:0] xa, input logic [15:0] xb,
                      input logic [15:0] xp);
    bus.in_valid = v;
    bus.a        = xa;
    bus.b        = xb;
    if (v) sb.push_back(xp);
    @(posedge clk);
    vpipe = {vpipe[0], v};
    #1;
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert (bus.p === 16'h0000) else begin
      failures++;
      $error("FAIL %s_p got=%h exp=0000", tag, bus.p);
    end
    checks++;
    assert (bus.out_valid === 1'b0) else begin
      failures++;
      $error("FAIL %s_valid got=%b exp=0", tag, bus.out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    vpipe    = 2'b00;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;

    vecs.push_back('{16'h3C00, 16'h4000, 16'h4000});
    vecs.push_back('{16'hBC00, 16'h4000, 16'hC000});
    vecs.push_back('{16'h0000, 16'h3C00, 16'h0000});
    vecs.push_back('{16'h8000, 16'h3C00, 16'h8000});
    vecs.push_back('{16'h7C00, 16'h3C00, 16'h7C00});
    vecs.push_back('{16'h7E00, 16'h3C00, 16'h7E00});
    vecs.push_back('{16'h7C00, 16'h0000, 16'h7E00});
    vecs.push_back('{16'h3555, 16'h3555, 16'h2F1C});
    vecs.push_back('{16'h7BFF, 16'h4000, 16'h7C00});
    vecs.push_back('{16'h0001, 16'h3C00, 16'h0001});
    vecs.push_back('{16'h0400, 16'h3800, 16'h0200});
    vecs.push_back('{16'h0001, 16'h3400, 16'h0000});
    vecs.push_back('{16'hC000, 16'hC000, 16'h4400});
    vecs.push_back('{16'hFC00, 16'hC000, 16'h7C00});
    vecs.push_back('{16'hFE00, 16'h3C00, 16'h7E00});
    vecs.push_back('{16'h03FF, 16'h3C01, 16'h0400});
    vecs.push_back('{16'h0000, 16'hFC00, 16'h7E00});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Each vector in isolation, separated by bubbles
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].p);
      step(1'b0, 16'h1234, 16'h5678, 16'h0000);
      step(1'b0, 16'h0000, 16'h0000, 16'h0000);
    end

    // Back-to-back stream, one per cycle
    foreach (vecs[i]) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].p);
    repeat (3) step(1'b0, 16'h0000, 16'h0000, 16'h0000);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL stream_drain got=%0d exp=0", sb.size());
    end

    // Reset asserted mid-stream discards in-flight results
    for (int i = 0; i < 4; i++) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].p);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    sb.delete();
    vpipe = 2'b00;
    bus.in_valid = 1'b1;
    bus.a = 16'h3C00;
    bus.b = 16'h3C00;
    @(posedge clk);
    #1;
    check_reset_state("held_reset");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) step(1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Recovery after reset
    step(1'b1, 16'h3555, 16'h3555, 16'h2F1C);
    step(1'b1, 16'h0400, 16'h3800, 16'h0200);
    repeat (3) step(1'b0, 16'h0000, 16'h0000, 16'h0000);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL final_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
